// File: rtl/prbs_pkg.sv
// Shared types and helpers for the LCG bit serializer: FSM state encoding,
// the default word width and the FIFO index width helper.
package prbs_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Address bits needed to index a FIFO of the given depth (never below 1).
  function automatic int fifo_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lcg_bit_serializer_word_fifo.sv
// Synchronous word FIFO (WIDTH x DEPTH) with full/empty/level flags and an
// asynchronous active-high reset. Push when full and pop when empty are ignored.
module word_fifo
  import prbs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW = fifo_idx_w(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcg_bit_serializer.sv
// Serializes LCG words into a valid/ready bit stream through a small word FIFO.
// Define LCG_VN_DEBIAS_EN to insert a von Neumann corrector on the bit stream.
module lcg_bit_serializer
  import prbs_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic [LW-1:0]    fifo_level,
  output logic             ovf,
  output state_t           state
);

  localparam int CW = $clog2(WIDTH) + 1;
`ifdef LCG_VN_DEBIAS_EN
  localparam int STEP = 2;
  localparam int LOAD = WIDTH / 2;
`else
  localparam int STEP = 1;
  localparam int LOAD = WIDTH;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0] shifted;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             head_bit;
  logic             bv;
  logic             adv;

  // Handshakes: a word moves when word_valid && word_ready, a bit moves when
  // bit_valid && bit_ready; a producer never retracts valid once raised.
  assign word_ready = !fifo_full;
  assign state      = state_q;
  assign bit_valid  = bv;
  assign bit_out    = bv & head_bit;

  assign head_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign shifted  = MSB_FIRST ? (sh_q << STEP) : (sh_q >> STEP);

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (word_valid && word_ready),
    .wdata (word_in),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef LCG_VN_DEBIAS_EN
  logic pair_bit;
  assign pair_bit = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
  // Equal pairs are dropped without waiting for the consumer.
  assign bv  = (state_q == ST_SHIFT) && (head_bit != pair_bit);
  assign adv = (state_q == ST_SHIFT) && (!bv || bit_ready);
`else
  assign bv  = (state_q == ST_SHIFT);
  assign adv = bv && bit_ready;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_head;
          cnt_d   = CW'(LOAD);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (adv) begin
          if (cnt_q == CW'(1)) begin
            // Reload on the final advance so back-to-back words have no bubble.
            if (!fifo_empty) begin
              pop   = 1'b1;
              sh_d  = fifo_head;
              cnt_d = CW'(LOAD);
            end else begin
              sh_d    = shifted;
              cnt_d   = '0;
              state_d = ST_EMPTY;
            end
          end else begin
            sh_d  = shifted;
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      sh_q    <= '0;
      cnt_q   <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      if (word_valid && !word_ready) ovf <= 1'b1;
    end
  end

endmodule
